aes128_job_ctrl: RTL

Job-level initiator for `aes128_hardened_top`. It accepts encryption jobs (key, plaintext, self-test flag) over a valid/ready request channel and drives the core's `start`/`key`/`plaintext`/`inject_fault` inputs. It monitors `valid`/`fault_alert`/`busy`, retries on fault, enforces a timeout and returns ciphertext plus status over a valid/ready response channel. It sits between the system bus adapter and the hardened core, and keeps a saturating fault counter for the security monitor.

---
 rtl/aes128_job_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/aes128_job_ctrl.sv
// Job-level initiator for the hardened AES-128 core: issues jobs, retries on fault alerts,
// enforces a wait timeout and returns ciphertext plus status over a valid/ready channel.
module aes128_job_ctrl #(
  parameter int unsigned MAX_RETRY      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [127:0] req_key,
  input  logic [127:0] req_plain,
  input  logic         req_selftest,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic [1:0]   rsp_status,
  output logic         core_start,
  output logic [127:0] core_key,
  output logic [127:0] core_plaintext,
  output logic         core_inject_fault,
  input  logic [127:0] core_ciphertext,
  input  logic         core_valid,
  input  logic         core_busy,
  input  logic         core_fault_alert,
  output logic [15:0]  fault_cnt
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [2:0]  MaxRetry    = 3'(MAX_RETRY);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] StatusOk           = 2'b00;
  localparam logic [1:0] StatusFault        = 2'b01;
  localparam logic [1:0] StatusTimeout      = 2'b10;
  localparam logic [1:0] StatusSelftestFail = 2'b11;

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [127:0] plain_q, plain_d;
  logic         selftest_q, selftest_d;
  logic [2:0]   attempt_q, attempt_d;
  logic [15:0]  timer_q, timer_d;
  logic [15:0]  fault_cnt_q, fault_cnt_d;
  logic [127:0] rsp_data_q, rsp_data_d;
  logic [1:0]   rsp_status_q, rsp_status_d;
  logic         timeout;
  logic         can_retry;

  assign timeout   = (timer_q == TimeoutLast);
  assign can_retry = ~selftest_q & (attempt_q < MaxRetry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = StIssue;
      StIssue: if (!core_busy) state_d = StWait;
      StWait: begin
        // Fault outranks valid, and valid outranks the timeout.
        if (core_fault_alert) begin
          state_d = can_retry ? StIssue : StResp;
        end else if (core_valid || timeout) begin
          state_d = StResp;
        end
      end
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    core_start = 1'b0;
    unique case (state_q)
      StIdle:  req_ready = 1'b1;
      StIssue: core_start = ~core_busy;
      StResp:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    key_d        = key_q;
    plain_d      = plain_q;
    selftest_d   = selftest_q;
    attempt_d    = attempt_q;
    timer_d      = timer_q;
    fault_cnt_d  = fault_cnt_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          key_d      = req_key;
          plain_d    = req_plain;
          selftest_d = req_selftest;
          attempt_d  = '0;
        end
      end
      StIssue: begin
        if (!core_busy) timer_d = '0;
      end
      StWait: begin
        timer_d = timer_q + 16'd1;
        if (core_fault_alert) begin
          if (selftest_q) begin
            // An alert is the expected outcome of a fault-injection self-test.
            rsp_status_d = StatusOk;
            rsp_data_d   = '0;
          end else begin
            if (fault_cnt_q != 16'hFFFF) fault_cnt_d = fault_cnt_q + 16'd1;
            if (can_retry) begin
              attempt_d = attempt_q + 3'd1;
            end else begin
              rsp_status_d = StatusFault;
              rsp_data_d   = '0;
            end
          end
        end else if (core_valid) begin
          rsp_status_d = selftest_q ? StatusSelftestFail : StatusOk;
          rsp_data_d   = selftest_q ? '0 : core_ciphertext;
        end else if (timeout) begin
          rsp_status_d = StatusTimeout;
          rsp_data_d   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q        <= '0;
      plain_q      <= '0;
      selftest_q   <= 1'b0;
      attempt_q    <= '0;
      timer_q      <= '0;
      fault_cnt_q  <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= StatusOk;
    end else begin
      key_q        <= key_d;
      plain_q      <= plain_d;
      selftest_q   <= selftest_d;
      attempt_q    <= attempt_d;
      timer_q      <= timer_d;
      fault_cnt_q  <= fault_cnt_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign core_key          = key_q;
  assign core_plaintext    = plain_q;
  assign core_inject_fault = selftest_q;
  assign fault_cnt         = fault_cnt_q;
  assign rsp_data          = rsp_data_q;
  assign rsp_status        = rsp_status_q;

endmodule
